// File: rtl/decoder_scan_if.sv
// Select handshake and decoded-output bundle for decoder_scan.
interface decoder_scan_if #(
   parameter int unsigned SEL_W = 2
);
   localparam int unsigned N = 1 << SEL_W;

   logic             en;
   logic             mode;
   logic             sel_valid;
   logic [SEL_W-1:0] sel;
   logic             sel_ready;
   logic [N-1:0]     y;
   logic [SEL_W-1:0] cur;
   logic             wrap;

   modport master (
      output en, mode, sel_valid, sel,
      input  sel_ready, y, cur, wrap
   );

   modport slave (
      input  en, mode, sel_valid, sel,
      output sel_ready, y, cur, wrap
   );
endinterface

// File: rtl/decoder_scan.sv
// Registered 1-of-2^SEL_W decoder: direct decode of a handshaked select,
// or autonomous round-robin scan with a programmable dwell per output.
module decoder_scan #(
   parameter int unsigned SEL_W      = 2,
   parameter int unsigned DWELL      = 4,
   parameter bit          ACTIVE_LOW = 1'b0
) (
   input  logic           clk,
   input  logic           rst,
   decoder_scan_if.slave  bus
);
   localparam int unsigned N      = 1 << SEL_W;
   localparam int unsigned DCNT_W = $clog2(DWELL + 1);
   localparam logic [DCNT_W-1:0] DCNT_RELOAD = DCNT_W'(DWELL - 1);
   localparam logic [N-1:0]      Y_IDLE      = {N{ACTIVE_LOW}};
   localparam logic [SEL_W-1:0]  CUR_LAST    = SEL_W'(N - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIRECT = 2'd1,
      SCAN   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [DCNT_W-1:0] dcnt_q, dcnt_d;
   logic [SEL_W-1:0]  cur_q, cur_d;
   logic [SEL_W-1:0]  cur_inc;
   logic [N-1:0]      y_q, y_d;
   logic [N-1:0]      oh_q, oh_d;
   logic              ready_q, ready_d;
   logic              wrap_q, wrap_d;
   logic              hs;

   // Polarity lives only in the output register; logic works on the one-hot form.
   assign oh_q    = y_q ^ Y_IDLE;
   assign hs      = bus.sel_valid & ready_q;
   assign cur_inc = cur_q + SEL_W'(1);

   // Next-state, next-output computation.
   always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      cur_d   = cur_q;
      oh_d    = oh_q;
      wrap_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.en) begin
               if (bus.mode) begin
                  state_d = SCAN;
                  cur_d   = '0;
                  oh_d    = N'(1);
                  dcnt_d  = DCNT_RELOAD;
               end else begin
                  state_d = DIRECT;
               end
            end
         end
         DIRECT: begin
            if (!bus.en || bus.mode) begin
               state_d = IDLE;
               cur_d   = '0;
               oh_d    = '0;
               dcnt_d  = '0;
            end else if (hs) begin
               cur_d  = bus.sel;
               oh_d   = N'(1) << bus.sel;
               dcnt_d = DCNT_RELOAD;
            end else if (dcnt_q != '0) begin
               dcnt_d = dcnt_q - DCNT_W'(1);
            end
         end
         SCAN: begin
            if (!bus.en || !bus.mode) begin
               state_d = IDLE;
               cur_d   = '0;
               oh_d    = '0;
               dcnt_d  = '0;
            end else if (dcnt_q == '0) begin
               cur_d  = cur_inc;
               oh_d   = N'(1) << cur_inc;
               dcnt_d = DCNT_RELOAD;
               wrap_d = (cur_q == CUR_LAST);
            end else begin
               dcnt_d = dcnt_q - DCNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cur_d   = '0;
            oh_d    = '0;
            dcnt_d  = '0;
         end
      endcase

      ready_d = (state_d == DIRECT) && (dcnt_d == '0);
      y_d     = oh_d ^ Y_IDLE;
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         dcnt_q  <= '0;
         cur_q   <= '0;
         y_q     <= Y_IDLE;
         ready_q <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dcnt_q  <= dcnt_d;
         cur_q   <= cur_d;
         y_q     <= y_d;
         ready_q <= ready_d;
         wrap_q  <= wrap_d;
      end
   end

   assign bus.y         = y_q;
   assign bus.cur       = cur_q;
   assign bus.sel_ready = ready_q;
   assign bus.wrap      = wrap_q;
endmodule

// File: tb/tb_decoder_scan.sv
// Directed bench for decoder_scan across three parameter sets.
module tb_decoder_scan;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   decoder_scan_if #(.SEL_W(2)) a_if ();
   decoder_scan_if #(.SEL_W(2)) b_if ();
   decoder_scan_if #(.SEL_W(3)) c_if ();

   decoder_scan #(.SEL_W(2), .DWELL(4), .ACTIVE_LOW(1'b0)) u_a (.clk(clk), .rst(rst), .bus(a_if));
   decoder_scan #(.SEL_W(2), .DWELL(2), .ACTIVE_LOW(1'b0)) u_b (.clk(clk), .rst(rst), .bus(b_if));
   decoder_scan #(.SEL_W(3), .DWELL(1), .ACTIVE_LOW(1'b1)) u_c (.clk(clk), .rst(rst), .bus(c_if));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic       mode;
      logic       valid;
      logic [1:0] sel;
      logic [3:0] y;
      logic [1:0] cur;
      logic       ready;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic en, input logic mode, input logic valid,
                               input logic [1:0] sel, input logic [3:0] y,
                               input logic [1:0] cur, input logic ready);
      vec_t v;
      v.en = en; v.mode = mode; v.valid = valid; v.sel = sel;
      v.y = y; v.cur = cur; v.ready = ready;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   logic [3:0] scan_seq [8];
   logic [7:0] oh;
   logic [7:0] ey;

   initial begin
      checks = 0;
      errors = 0;
      scan_seq[0] = 4'b0001; scan_seq[1] = 4'b0001;
      scan_seq[2] = 4'b0010; scan_seq[3] = 4'b0010;
      scan_seq[4] = 4'b0100; scan_seq[5] = 4'b0100;
      scan_seq[6] = 4'b1000; scan_seq[7] = 4'b1000;

      // direct decode: accepts of 2 then 1 with valid held, then 3
      vq.push_back(mk(1,0,0,0,4'b0000,0,1));
      vq.push_back(mk(1,0,1,2,4'b0100,2,0));
      vq.push_back(mk(1,0,1,1,4'b0100,2,0));
      vq.push_back(mk(1,0,1,1,4'b0100,2,0));
      vq.push_back(mk(1,0,1,1,4'b0100,2,1));
      vq.push_back(mk(1,0,1,1,4'b0010,1,0));
      vq.push_back(mk(1,0,0,0,4'b0010,1,0));
      vq.push_back(mk(1,0,0,0,4'b0010,1,0));
      vq.push_back(mk(1,0,0,0,4'b0010,1,1));
      vq.push_back(mk(1,0,1,3,4'b1000,3,0));
      vq.push_back(mk(1,0,0,0,4'b1000,3,0));
      vq.push_back(mk(1,0,0,0,4'b1000,3,0));
      vq.push_back(mk(1,0,0,0,4'b1000,3,1));
      // mode switch with a handshake offered: gap cycle, then scan from 0
      vq.push_back(mk(1,1,1,0,4'b0000,0,0));
      vq.push_back(mk(1,1,1,0,4'b0001,0,0));
      vq.push_back(mk(1,1,0,0,4'b0001,0,0));
      vq.push_back(mk(1,1,0,0,4'b0001,0,0));
      vq.push_back(mk(1,1,0,0,4'b0001,0,0));
      vq.push_back(mk(1,1,0,0,4'b0010,1,0));
      vq.push_back(mk(1,1,0,0,4'b0010,1,0));
      vq.push_back(mk(1,1,0,0,4'b0010,1,0));
      vq.push_back(mk(1,1,0,0,4'b0010,1,0));
      vq.push_back(mk(1,1,0,0,4'b0100,2,0));
      vq.push_back(mk(1,1,0,0,4'b0100,2,0));
      // drop en while cur=2, then restart with full dwell
      vq.push_back(mk(0,1,0,0,4'b0000,0,0));
      vq.push_back(mk(1,1,0,0,4'b0001,0,0));
      vq.push_back(mk(1,1,0,0,4'b0001,0,0));
      vq.push_back(mk(1,1,0,0,4'b0001,0,0));
      vq.push_back(mk(1,1,0,0,4'b0001,0,0));
      vq.push_back(mk(1,1,0,0,4'b0010,1,0));
      // back to direct; en low beats a same-cycle handshake
      vq.push_back(mk(1,0,0,0,4'b0000,0,0));
      vq.push_back(mk(1,0,0,0,4'b0000,0,1));
      vq.push_back(mk(0,0,1,3,4'b0000,0,0));
      vq.push_back(mk(1,0,0,0,4'b0000,0,1));
      vq.push_back(mk(1,0,1,3,4'b1000,3,0));

      rst = 1'b1;
      a_if.en = 0; a_if.mode = 0; a_if.sel_valid = 0; a_if.sel = '0;
      b_if.en = 0; b_if.mode = 0; b_if.sel_valid = 0; b_if.sel = '0;
      c_if.en = 0; c_if.mode = 0; c_if.sel_valid = 0; c_if.sel = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_a_y", 32'(a_if.y), 32'h0);
      chk("rst_a_cur", 32'(a_if.cur), 32'h0);
      chk("rst_a_ready", 32'(a_if.sel_ready), 32'h0);
      chk("rst_a_wrap", 32'(a_if.wrap), 32'h0);
      chk("rst_c_y", 32'(c_if.y), 32'hff);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < vq.size(); i++) begin
         a_if.en = vq[i].en; a_if.mode = vq[i].mode;
         a_if.sel_valid = vq[i].valid; a_if.sel = vq[i].sel;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_y", i), 32'(a_if.y), 32'(vq[i].y));
         chk($sformatf("vec%0d_cur", i), 32'(a_if.cur), 32'(vq[i].cur));
         chk($sformatf("vec%0d_ready", i), 32'(a_if.sel_ready), 32'(vq[i].ready));
         chk($sformatf("vec%0d_wrap", i), 32'(a_if.wrap), 32'h0);
      end

      // scan, DWELL=2: two-cycle steps, wrap with each return to 0001
      b_if.en = 1; b_if.mode = 1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("scan%0d_y", i), 32'(b_if.y), 32'(scan_seq[i % 8]));
         chk($sformatf("scan%0d_cur", i), 32'(b_if.cur), 32'((i / 2) % 4));
         chk($sformatf("scan%0d_wrap", i), 32'(b_if.wrap), 32'((i > 0) && (i % 8 == 0)));
         chk($sformatf("scan%0d_ready", i), 32'(b_if.sel_ready), 32'h0);
      end
      b_if.en = 0;

      // active-low, DWELL=1: one accept per cycle
      c_if.en = 1; c_if.mode = 0; c_if.sel_valid = 0;
      @(posedge clk);
      #1;
      chk("al_entry_y", 32'(c_if.y), 32'hff);
      chk("al_entry_ready", 32'(c_if.sel_ready), 32'h1);
      for (int k = 0; k < 8; k++) begin
         c_if.sel_valid = 1; c_if.sel = 3'(k);
         @(posedge clk);
         #1;
         oh = 8'h01 << k;
         ey = ~oh;
         chk($sformatf("al%0d_y", k), 32'(c_if.y), 32'(ey));
         chk($sformatf("al%0d_cur", k), 32'(c_if.cur), 32'(k));
         chk($sformatf("al%0d_ready", k), 32'(c_if.sel_ready), 32'h1);
      end
      c_if.en = 0; c_if.sel_valid = 0;
      @(posedge clk);
      #1;
      chk("al_off_y", 32'(c_if.y), 32'hff);
      chk("al_off_ready", 32'(c_if.sel_ready), 32'h0);

      // mid-cycle asynchronous reset while u_a is showing 1000
      chk("pre_rst_a_y", 32'(a_if.y), 32'h8);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_a_y", 32'(a_if.y), 32'h0);
      chk("arst_a_cur", 32'(a_if.cur), 32'h0);
      chk("arst_a_ready", 32'(a_if.sel_ready), 32'h0);
      chk("arst_a_wrap", 32'(a_if.wrap), 32'h0);
      chk("arst_c_y", 32'(c_if.y), 32'hff);
      @(negedge clk);
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
